// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key tracker: prefix byte values, decoder
// state encoding and the 9-bit {ext, code} key identifier.
package ps2_pkg;

    localparam int unsigned KEY_CODE_W = 9;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_NUL = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_code_t;

endpackage

// File: rtl/ps2_key_table.sv
// MAX_KEYS-entry CAM of held key codes.
// Ports: clk/clrn clock and async reset; flush synchronous clear;
//        lookup_code key compared against valid slots; insert writes
//        lookup_code into the lowest free slot; remove frees the slot that
//        holds lookup_code; hit/full lookup status; count popcount of valid
//        slots; busy registered (count != 0).
module ps2_key_table
    import ps2_pkg::*;
#(
    parameter  int unsigned MAX_KEYS = 4,
    localparam int unsigned IDX_W    = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1,
    localparam int unsigned CNT_W    = $clog2(MAX_KEYS + 1)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  key_code_t        lookup_code,
    input  logic             insert,
    input  logic             remove,
    output logic             hit,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    key_code_t           code_q [MAX_KEYS];
    logic [MAX_KEYS-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                busy_q;
    logic [IDX_W-1:0]    hit_idx;
    logic [IDX_W-1:0]    free_idx;
    logic                free_found;

    // Match only valid slots; codes are unique so the first hit is the hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (!hit && valid_q[i] && (code_q[i] == lookup_code)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index free slot.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        full = &valid_q;
    end

    // Next valid vector and its popcount.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < MAX_KEYS; i++) begin
                if (insert && !full && (free_idx == IDX_W'(i))) valid_d[i] = 1'b1;
                if (remove && hit && (hit_idx == IDX_W'(i)))    valid_d[i] = 1'b0;
            end
        end
        count_d = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < MAX_KEYS; i++) code_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            busy_q  <= (count_d != '0);
            for (int i = 0; i < MAX_KEYS; i++) begin
                if (!flush && insert && !full && (free_idx == IDX_W'(i))) begin
                    code_q[i] <= lookup_code;
                end
            end
        end
    end

    assign count = count_q;
    assign busy  = busy_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder with multi-key tracking. Decodes E0/F0 prefixes,
// keeps up to MAX_KEYS held keys and emits one-cycle make/break events.
// Optional macro PS2_TYPEMATIC_EN: repeats of held keys raise an event with
// event_repeat=1; otherwise repeats are suppressed and event_repeat is 0.
// Ports: clk, clrn (async active-low reset); data/ready input bytes;
//        clear synchronous flush; event_valid/event_code/event_make/
//        event_repeat event outputs; pressing, key_count, overflow status.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter  int unsigned MAX_KEYS = 4,
    localparam int unsigned CNT_W    = $clog2(MAX_KEYS + 1)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             clear,
    output logic             event_valid,
    output logic [8:0]       event_code,
    output logic             event_make,
    output logic             event_repeat,
    output logic             pressing,
    output logic [CNT_W-1:0] key_count,
    output logic             overflow
);

    ps2_state_e state_q, state_d;
    logic       ev_valid_q, ev_valid_d;
    key_code_t  ev_code_q, ev_code_d;
    logic       ev_make_q, ev_make_d;
    logic       ovf_q, ovf_d;
    logic       is_make, is_break;
    logic       tbl_insert, tbl_remove, tbl_hit, tbl_full;
    key_code_t  cur_code;
`ifdef PS2_TYPEMATIC_EN
    logic       ev_rep_q, ev_rep_d;
`endif

    // Key identifier for the current byte; ext comes from the prefix state.
    assign cur_code = '{ext: (state_q == S_EXT) || (state_q == S_EXT_BRK), code: data};

    ps2_key_table #(.MAX_KEYS(MAX_KEYS)) u_table (
        .clk         (clk),
        .clrn        (clrn),
        .flush       (clear),
        .lookup_code (cur_code),
        .insert      (tbl_insert),
        .remove      (tbl_remove),
        .hit         (tbl_hit),
        .full        (tbl_full),
        .count       (key_count),
        .busy        (pressing)
    );

    // Decoder next-state and event generation.
    always_comb begin
        state_d    = state_q;
        ev_valid_d = 1'b0;
        ev_code_d  = ev_code_q;
        ev_make_d  = ev_make_q;
        ovf_d      = ovf_q;
        tbl_insert = 1'b0;
        tbl_remove = 1'b0;
        is_make    = 1'b0;
        is_break   = 1'b0;
`ifdef PS2_TYPEMATIC_EN
        ev_rep_d   = ev_rep_q;
`endif

        if (clear) begin
            state_d   = S_IDLE;
            ev_code_d = '0;
            ev_make_d = 1'b0;
            ovf_d     = 1'b0;
`ifdef PS2_TYPEMATIC_EN
            ev_rep_d  = 1'b0;
`endif
        end else if (ready && (data != PS2_NUL)) begin
            case (state_q)
                S_IDLE: begin
                    if (data == PS2_EXT)      state_d = S_EXT;
                    else if (data == PS2_BRK) state_d = S_BRK;
                    else                      is_make = 1'b1;
                end
                S_EXT: begin
                    if (data == PS2_BRK) begin
                        state_d = S_EXT_BRK;
                    end else if (data != PS2_EXT) begin
                        is_make = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                // A second prefix after F0 is a protocol error: drop to idle.
                S_BRK, S_EXT_BRK: begin
                    state_d  = S_IDLE;
                    is_break = (data != PS2_EXT) && (data != PS2_BRK);
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (is_make) begin
            if (tbl_hit) begin
`ifdef PS2_TYPEMATIC_EN
                ev_valid_d = 1'b1;
                ev_code_d  = cur_code;
                ev_make_d  = 1'b1;
                ev_rep_d   = 1'b1;
`endif
            end else if (!tbl_full) begin
                tbl_insert = 1'b1;
                ev_valid_d = 1'b1;
                ev_code_d  = cur_code;
                ev_make_d  = 1'b1;
`ifdef PS2_TYPEMATIC_EN
                ev_rep_d   = 1'b0;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (is_break && tbl_hit) begin
            tbl_remove = 1'b1;
            ev_valid_d = 1'b1;
            ev_code_d  = cur_code;
            ev_make_d  = 1'b0;
`ifdef PS2_TYPEMATIC_EN
            ev_rep_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= S_IDLE;
            ev_valid_q <= 1'b0;
            ev_code_q  <= '0;
            ev_make_q  <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef PS2_TYPEMATIC_EN
            ev_rep_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            ev_make_q  <= ev_make_d;
            ovf_q      <= ovf_d;
`ifdef PS2_TYPEMATIC_EN
            ev_rep_q   <= ev_rep_d;
`endif
        end
    end

    assign event_valid = ev_valid_q;
    assign event_code  = ev_code_q;
    assign event_make  = ev_make_q;
    assign overflow    = ovf_q;
`ifdef PS2_TYPEMATIC_EN
    assign event_repeat = ev_rep_q;
`else
    assign event_repeat = 1'b0;
`endif

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised successor to the single-key press/release detector. It consumes decoded PS/2 scan-code bytes and decodes the E0 (extended) and F0 (break) prefixes. It tracks up to MAX_KEYS simultaneously held keys and emits one-cycle make/break events to downstream display and ASCII logic. Typematic repeats of held keys are suppressed.

Parameters:
MAX_KEYS, 4, number of simultaneously tracked keys (1..8)
CNT_W, $clog2(MAX_KEYS+1), width of key_count (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
clrn  input  1  asynchronous active-low reset
data  input  8  scan-code byte from PS/2 receiver
ready  input  1  data valid this cycle; one byte consumed per ready cycle
clear  input  1  synchronous flush of key table and decoder state
event_valid  output  1  one-cycle pulse: new make/break event
event_code  output  9  {ext, code}; ext=1 when byte was prefixed by E0
event_make  output  1  1 = press, 0 = release; valid with event_valid
event_repeat  output  1  typematic repeat flag (see Optional Feature)
pressing  output  1  1 when key_count != 0
key_count  output  CNT_W  number of keys currently held
overflow  output  1  sticky; set when a make arrives while table full

Behaviour:
- Reset (clrn=0, async): state=S_IDLE, table empty, event_valid=0, event_code=0, event_make=0, event_repeat=0, pressing=0, key_count=0, overflow=0.
- clear=1: same values as reset at next edge. Overrides ready in the same cycle.
- Decoder FSM, advances only on ready=1:
  - S_IDLE: E0 -> S_EXT; F0 -> S_BRK; other -> make {0,data}, stay S_IDLE.
  - S_EXT: F0 -> S_EXT_BRK; E0 -> stay S_EXT; other -> make {1,data}, -> S_IDLE.
  - S_BRK: E0 or F0 -> protocol error, no event, -> S_IDLE; other -> break {0,data}, -> S_IDLE.
  - S_EXT_BRK: E0 or F0 -> error, -> S_IDLE; other -> break {1,data}, -> S_IDLE.
- Byte 8'h00 is ignored in all states: no state change.
- Make handling:
  - Code already in table: typematic repeat, no table change.
  - Code absent, free slot exists: insert at lowest-index free slot; event_valid=1, event_make=1.
  - Code absent, table full: no insert, no event, overflow<=1.
- Break handling:
  - Code present: clear that slot's valid bit; event_valid=1, event_make=0.
  - Code absent: silently ignored.
- Latency: event outputs, key_count and pressing update on the edge that samples the final byte (registered, one cycle after ready is high). event_valid is high for exactly one cycle.
- event_code and event_make hold their last value when event_valid=0.
- Make and break never occur on the same cycle (one byte per cycle), so there is no simultaneous-event case.
- key_count equals the popcount of the slot valid bits. Slots never contain duplicate codes.
- overflow clears only on reset or clear.

Optional Feature:
PS2_TYPEMATIC_EN:
- Defined: a make for a code already in the table produces event_valid=1, event_make=1, event_repeat=1. The table is unchanged.
- Undefined: repeats are fully suppressed and event_repeat is tied to 0.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_NUL=8'h00
  - the 2-bit state encoding S_IDLE/S_EXT/S_BRK/S_EXT_BRK
  - the 9-bit key-code type
- Sub-module ps2_key_table (MAX_KEYS-entry CAM) provides:
  - lookup hit and hit index
  - lowest free index and full flag
  - insert and remove strobes
  - popcount
- The top level holds the decoder FSM and the event registers.

Test Plan:
- Bytes 1C, F0, 1C -> make event code 0x01C, then break event 0x01C; key_count 1 then 0; pressing follows key_count.
- Bytes E0, 75, E0, F0, 75 -> make 0x175, then break 0x175; no event on any prefix byte.
- Bytes 1C, 1C, 1C (typematic) -> one event only without macro; with PS2_TYPEMATIC_EN, two further events with event_repeat=1.
- MAX_KEYS=4: makes 1C, 1B, 23, 2B, 34 -> four events, key_count=4, fifth byte gives no event and overflow=1; then F0, 1B -> break 0x01B, key_count=3; then 34 inserts into slot 1.
- Bytes F0, F0, 1C -> no event, state back to S_IDLE, then 1C is a make; break of an unheld code (F0, 4D) gives no event.
- Assert clrn=0 in S_EXT_BRK with 2 keys held -> all outputs reset immediately; next byte 75 is decoded as a non-extended make 0x075.
